glu_gate_mul: RTL and testbench
===============================

# glu_gate_mul

Streaming element-wise gate multiplier for the gated-linear-unit FFN path: joins the SiLU-activated gate vector stream with the up-projection vector stream, multiplies lane-by-lane in signed fixed point, rounds half away from zero, saturates, and emits the gated vector toward the down-projection stage. It is a 2-stage valid/ready pipeline with a per-vector saturation indicator and a saturation event counter.

## Interface
- DIM, 1, number of lanes per vector
- WIDTH, 16, lane width in bits (signed two's complement)
- FRAC, 8, fractional bits (Q8.8 by default); constraint 1 <= FRAC < WIDTH
- CNT_WIDTH, 32, saturation counter width

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- gate_valid  in  1  gate vector valid
- gate_ready  out  1  gate vector accepted when gate_valid & gate_ready
- gate_vec  in  DIM*WIDTH  SiLU output vector, lane j at [j*WIDTH +: WIDTH]
- up_valid  in  1  up vector valid
- up_ready  out  1  up vector accepted when up_valid & up_ready
- up_vec  in  DIM*WIDTH  up-projection vector, same packing
- out_valid  out  1  gated vector valid
- out_ready  in  1  downstream accept
- out_vec  out  DIM*WIDTH  gated vector, same packing
- out_sat  out  1  at least one lane of out_vec saturated
- sat_clr  in  1  synchronous clear of sat_count
- sat_count  out  CNT_WIDTH  number of transferred output vectors with out_sat=1

## Operation
- Join: a pair is consumed only when both gate_valid and up_valid are 1 and stage 1 can advance; gate_ready = up_valid & s1_adv, up_ready = gate_valid & s1_adv. Never consumes one side alone.
- s1_adv = !s1_valid | s2_adv; s2_adv = !out_valid | out_ready. Full throughput (one vector/cycle) when out_ready is held 1.
- Stage 1: registers per-lane full product p = gate*up (2*WIDTH signed) and s1_valid.
- Stage 2: per lane, m = |p| + 2^(FRAC-1), r = m >> FRAC, result = sign ? -r : r (round half away from zero, computed in 2*WIDTH+1 bits). Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; lane sat flag set if clamped. Registers out_vec, out_sat (OR of lane flags), out_valid.
- While out_valid & !out_ready, out_vec/out_sat hold stable; stage 1 holds if also full.
- sat_count increments by 1 on each out_valid & out_ready with out_sat=1; sticks at all-ones. sat_clr has priority over increment in the same cycle (result 0).

## Timing
- Reset values: out_valid 0, out_vec 0, out_sat 0, sat_count 0, s1_valid 0. gate_ready/up_ready are combinational and 0 whenever the other side is invalid.
- Latency: input handshake in cycle N -> out_valid in cycle N+2 with no stall.
- Ready paths are combinational from out_ready and the opposite valid; no combinational valid->valid path to out_valid.
- Reset asserted mid-transfer: all in-flight vectors discarded, outputs return to reset values asynchronously; first acceptance possible on the first edge after rst_n deasserts.
- Backpressure with 2 vectors in flight: both inputs' ready drop to 0 in the same cycle; no data lost or duplicated.

## Structure
- Shared package (accel_pkg): fixed-point helper function for round-half-away + saturate, parameterised lane typedef, default WIDTH/FRAC constants, shared with silu and other activation stages.
- One natural sub-module: glu_lane_mul (one lane: product register, round, saturate, sat flag), instantiated DIM times via generate; top holds join, valid/ready control and counter.

## Test plan
- DIM=1, Q8.8: gate 0x0100, up 0x0200 -> out 0x0200, out_sat 0, two cycles after handshake; gate 0xFF80, up 0x0080 -> 0xFFC0.
- Rounding: 0x0001*0x0080 -> 0x0001; 0xFFFF*0x0080 -> 0xFFFF; 0x0001*0x007F -> 0x0000.
- Saturation: 0x7FFF*0x7FFF -> 0x7FFF, out_sat 1; 0x8000*0x7FFF -> 0x8000, out_sat 1; 0x8000*0x8000 -> 0x7FFF; sat_count 3 after three transfers; sat_clr with concurrent saturated transfer -> 0.
- Join skew: up_valid asserted 3 cycles after gate_valid -> no ready on either side until both valid; single output produced.
- Random valid/out_ready toggling, DIM=4, 1000 vectors -> output stream matches scoreboard in order, no drop/duplicate, out_vec stable during stall.
- Reset asserted with 2 vectors in flight -> out_valid 0 immediately, no stale vector emitted after release, sat_count 0.

Source files
------------

// File: rtl/glu_gate_mul_pkg.sv
// Shared fixed-point helpers for the FFN activation/gating stages.
// All rounding math is done at 66 bits so any lane width up to 32 fits.
package glu_gate_mul_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;
  localparam int MAX_WIDTH = 32;

  typedef logic signed [DEF_WIDTH-1:0] lane_t;

  // Round half away from zero: r = sign(p) * ((|p| + 2^(frac-1)) >> frac).
  function automatic logic signed [65:0] round_half_away(input logic signed [63:0] p,
                                                         input int frac);
    logic [64:0]        mag;
    logic signed [65:0] r;
    mag = p[63] ? (65'd0 - 65'(p)) : 65'(p);
    mag = mag + (65'd1 << (frac - 1));
    r   = $signed({1'b0, mag >> frac});
    return p[63] ? -r : r;
  endfunction

  function automatic logic signed [65:0] lane_max(input int w);
    return (66'sd1 <<< (w - 1)) - 66'sd1;
  endfunction

  function automatic logic signed [65:0] lane_min(input int w);
    return -(66'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/glu_gate_mul_lane.sv
// One lane of the gate multiplier: product register, round, saturate, sat flag.
module glu_lane_mul
  import glu_gate_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld1,
  input  logic             ld2,
  input  logic [WIDTH-1:0] gate,
  input  logic [WIDTH-1:0] up,
  output logic [WIDTH-1:0] res,
  output logic             sat
);

  localparam logic signed [65:0] MAXV = lane_max(WIDTH);
  localparam logic signed [65:0] MINV = lane_min(WIDTH);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [65:0]        rnd;

  assign rnd = round_half_away(64'(prod), FRAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod <= '0;
    else if (ld1) prod <= $signed(gate) * $signed(up);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      sat <= 1'b0;
    end else if (ld2) begin
      if (rnd > MAXV) begin
        res <= {1'b0, {(WIDTH-1){1'b1}}};
        sat <= 1'b1;
      end else if (rnd < MINV) begin
        res <= {1'b1, {(WIDTH-1){1'b0}}};
        sat <= 1'b1;
      end else begin
        res <= rnd[WIDTH-1:0];
        sat <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/glu_gate_mul.sv
// GLU gate multiplier: joins gate/up streams, 2-stage lane multiply with
// round-half-away + saturation, valid/ready backpressure, saturation counter.
module glu_gate_mul
  import glu_gate_mul_pkg::*;
#(
  parameter int DIM       = 1,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAC      = DEF_FRAC,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gate_valid,
  output logic                 gate_ready,
  input  logic [DIM*WIDTH-1:0] gate_vec,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [DIM*WIDTH-1:0] up_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM*WIDTH-1:0] out_vec,
  output logic                 out_sat,
  input  logic                 sat_clr,
  output logic [CNT_WIDTH-1:0] sat_count
);

  localparam int STAGES = 2;

  if (FRAC < 1 || FRAC >= WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_cfg
    $error("glu_gate_mul: unsupported WIDTH/FRAC");
  end

  // vld_pipe[1] = stage-1 product valid, vld_pipe[2] = out_valid
  logic [STAGES:1] vld_pipe;
  logic            s1_adv, s2_adv, in_fire, ld2;
  logic [DIM-1:0]  lane_sat;

  assign s2_adv     = !vld_pipe[2] | out_ready;
  assign s1_adv     = !vld_pipe[1] | s2_adv;
  assign gate_ready = up_valid & s1_adv;
  assign up_ready   = gate_valid & s1_adv;
  assign in_fire    = gate_valid & up_valid & s1_adv;
  assign ld2        = s2_adv & vld_pipe[1];
  assign out_valid  = vld_pipe[2];
  assign out_sat    = |lane_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else begin
      if (s1_adv) vld_pipe[1] <= in_fire;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
    end
  end

  for (genvar j = 0; j < DIM; j++) begin : g_lane
    glu_lane_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld1   (in_fire),
      .ld2   (ld2),
      .gate  (gate_vec[j*WIDTH +: WIDTH]),
      .up    (up_vec[j*WIDTH +: WIDTH]),
      .res   (out_vec[j*WIDTH +: WIDTH]),
      .sat   (lane_sat[j])
    );
  end

  // Clear wins over a same-cycle increment; counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count <= '0;
    else if (sat_clr) sat_count <= '0;
    else if (out_valid && out_ready && out_sat && !(&sat_count))
      sat_count <= sat_count + 1'b1;
  end

endmodule

// File: tb/tb_glu_gate_mul.sv
// Self-checking bench for glu_gate_mul (DIM=4, Q8.8) with a behavioural model.
module tb_glu_gate_mul;

  localparam int DIM  = 4;
  localparam int W    = 16;
  localparam int FRAC = 8;
  localparam int CW   = 32;
  localparam int NVEC = 1000;

  logic              clk = 0;
  logic              rst_n = 0;
  logic              gate_valid = 0, up_valid = 0, out_ready = 0, sat_clr = 0;
  logic [DIM*W-1:0]  gate_vec = '0, up_vec = '0;
  logic              gate_ready, up_ready, out_valid, out_sat;
  logic [DIM*W-1:0]  out_vec;
  logic [CW-1:0]     sat_count;

  int errors = 0;
  int checks = 0;

  glu_gate_mul #(.DIM(DIM), .WIDTH(W), .FRAC(FRAC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .gate_valid(gate_valid), .gate_ready(gate_ready), .gate_vec(gate_vec),
    .up_valid(up_valid), .up_ready(up_ready), .up_vec(up_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .out_sat(out_sat), .sat_clr(sat_clr), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, round half away from zero, clamp.
  function automatic logic [W-1:0] ref_lane(input logic [W-1:0] g, input logic [W-1:0] u,
                                            output bit s);
    longint p, mag, r, lim;
    p   = longint'($signed(g)) * longint'($signed(u));
    mag = (p < 0) ? -p : p;
    r   = (mag + 2**(FRAC-1)) / (2**FRAC);
    if (p < 0) r = -r;
    lim = 2**(W-1);
    s = 0;
    if (r > lim - 1) begin r = lim - 1; s = 1; end
    else if (r < -lim) begin r = -lim; s = 1; end
    return r[W-1:0];
  endfunction

  function automatic logic [DIM*W-1:0] ref_vec(input logic [DIM*W-1:0] g,
                                               input logic [DIM*W-1:0] u, output bit s);
    logic [DIM*W-1:0] v;
    bit ls;
    s = 0;
    for (int j = 0; j < DIM; j++) begin
      v[j*W +: W] = ref_lane(g[j*W +: W], u[j*W +: W], ls);
      s |= ls;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_lane();
    logic [W-1:0] x;
    if ($urandom_range(0, 1) == 1) x = W'($urandom);
    else x = W'($urandom_range(0, 1023) - 512);
    return x;
  endfunction

  function automatic logic [DIM*W-1:0] rnd_vec();
    logic [DIM*W-1:0] v;
    for (int j = 0; j < DIM; j++) v[j*W +: W] = rnd_lane();
    return v;
  endfunction

  // Drives one splatted pair with out_ready=1; returns output and latency in cycles.
  task automatic run_one(input logic [W-1:0] g, input logic [W-1:0] u,
                         output logic [DIM*W-1:0] ov, output logic os, output int lat);
    int n;
    @(negedge clk);
    gate_vec = {DIM{g}}; up_vec = {DIM{u}};
    gate_valid = 1; up_valid = 1; out_ready = 1;
    #1;
    n = 0;
    while (!(gate_ready && up_ready) && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    gate_valid = 0; up_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    ov = out_vec; os = out_sat;
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    gate_valid = 1; up_valid = 0;
    @(posedge clk);
    @(negedge clk);
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (out_vec !== '0) begin errors++; $display("FAIL reset_out_vec got=%h want=0", out_vec); end
    checks++;
    if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got=%b want=0", out_sat); end
    checks++;
    if (sat_count !== '0) begin errors++; $display("FAIL reset_sat_count got=%0d want=0", sat_count); end
    checks++;
    if (gate_ready !== 1'b0) begin errors++; $display("FAIL reset_gate_ready got=%b want=0", gate_ready); end
    checks++;
    gate_valid = 0;
    rst_n = 1;
  endtask

  task automatic test_basic();
    logic [W-1:0] g[2] = '{16'h0100, 16'hFF80};
    logic [W-1:0] u[2] = '{16'h0200, 16'h0080};
    logic [W-1:0] e[2] = '{16'h0200, 16'hFFC0};
    logic [DIM*W-1:0] ov; logic os; int lat;
    for (int i = 0; i < 2; i++) begin
      run_one(g[i], u[i], ov, os, lat);
      if (ov !== {DIM{e[i]}} || os !== 1'b0) begin
        errors++; $display("FAIL basic_%0d got=%h/%b want=%h/0", i, ov, os, {DIM{e[i]}});
      end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL basic_latency_%0d got=%0d want=2", i, lat); end
      checks++;
    end
  endtask

  task automatic test_round();
    logic [W-1:0] g[3] = '{16'h0001, 16'hFFFF, 16'h0001};
    logic [W-1:0] u[3] = '{16'h0080, 16'h0080, 16'h007F};
    logic [W-1:0] e[3] = '{16'h0001, 16'hFFFF, 16'h0000};
    logic [DIM*W-1:0] ov; logic os; int lat;
    for (int i = 0; i < 3; i++) begin
      run_one(g[i], u[i], ov, os, lat);
      if (ov !== {DIM{e[i]}} || os !== 1'b0 || lat !== 2) begin
        errors++; $display("FAIL round_%0d got=%h/%b lat=%0d want=%h/0 lat=2", i, ov, os, lat, {DIM{e[i]}});
      end
      checks++;
    end
  endtask

  task automatic test_sat();
    logic [W-1:0] g[3] = '{16'h7FFF, 16'h8000, 16'h8000};
    logic [W-1:0] u[3] = '{16'h7FFF, 16'h7FFF, 16'h8000};
    logic [W-1:0] e[3] = '{16'h7FFF, 16'h8000, 16'h7FFF};
    logic [DIM*W-1:0] ov; logic os; int lat; int n;
    @(negedge clk); sat_clr = 1;
    @(negedge clk); sat_clr = 0;
    for (int i = 0; i < 3; i++) begin
      run_one(g[i], u[i], ov, os, lat);
      if (ov !== {DIM{e[i]}} || os !== 1'b1) begin
        errors++; $display("FAIL sat_%0d got=%h/%b want=%h/1", i, ov, os, {DIM{e[i]}});
      end
      checks++;
    end
    @(negedge clk);
    if (sat_count !== 3) begin errors++; $display("FAIL sat_count got=%0d want=3", sat_count); end
    checks++;
    // Saturated vector held at the output, then transferred in the same cycle as sat_clr.
    out_ready = 0;
    gate_vec = {DIM{16'h7FFF}}; up_vec = {DIM{16'h7FFF}};
    gate_valid = 1; up_valid = 1;
    @(negedge clk);
    gate_valid = 0; up_valid = 0;
    n = 0;
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    if (out_valid !== 1'b1 || out_sat !== 1'b1) begin
      errors++; $display("FAIL sat_clr_setup got=%b/%b want=1/1", out_valid, out_sat);
    end
    checks++;
    out_ready = 1; sat_clr = 1;
    @(negedge clk);
    sat_clr = 0;
    if (sat_count !== 0) begin errors++; $display("FAIL sat_clr_priority got=%0d want=0", sat_count); end
    checks++;
  endtask

  task automatic test_join_skew();
    int nout;
    logic [DIM*W-1:0] seen;
    @(negedge clk);
    out_ready = 1;
    gate_vec = {DIM{16'h0300}}; up_vec = {DIM{16'hFE00}};
    gate_valid = 1; up_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (gate_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL join_wait_%0d gate_ready=%b out_valid=%b want=0/0", i, gate_ready, out_valid);
      end
      checks++;
      @(negedge clk);
    end
    up_valid = 1;
    #1;
    if (gate_ready !== 1'b1 || up_ready !== 1'b1) begin
      errors++; $display("FAIL join_ready got=%b/%b want=1/1", gate_ready, up_ready);
    end
    checks++;
    @(negedge clk);
    gate_valid = 0; up_valid = 0;
    nout = 0; seen = '0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin nout++; seen = out_vec; end
      @(negedge clk);
    end
    if (nout !== 1 || seen !== {DIM{16'hFA00}}) begin
      errors++; $display("FAIL join_output count=%0d vec=%h want=1/%h", nout, seen, {DIM{16'hFA00}});
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [DIM*W-1:0] exp_q[$];
    bit               exp_s[$];
    logic [DIM*W-1:0] ev, pv;
    bit               es;
    logic             ps;
    bit               fired, held;
    int               sent, got, cyc, nsat;
    @(negedge clk); sat_clr = 1;
    @(negedge clk); sat_clr = 0;
    sent = 0; got = 0; cyc = 0; nsat = 0; fired = 0; held = 0; pv = '0; ps = 0;
    while (got < NVEC && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!gate_valid || fired) begin
        gate_valid = (sent < NVEC) && ($urandom_range(0, 3) != 0);
        gate_vec = rnd_vec();
      end
      if (!up_valid || fired) begin
        up_valid = (sent < NVEC) && ($urandom_range(0, 3) != 0);
        up_vec = rnd_vec();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (held) begin
        if (out_valid !== 1'b1 || out_vec !== pv || out_sat !== ps) begin
          errors++; $display("FAIL stall_stable cyc=%0d got=%b/%h/%b want=1/%h/%b", cyc, out_valid, out_vec, out_sat, pv, ps);
        end
        checks++;
      end
      fired = gate_valid && up_valid && gate_ready && up_ready;
      if (fired) begin
        exp_q.push_back(ref_vec(gate_vec, up_vec, es));
        exp_s.push_back(es);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra cyc=%0d got=%h want=none", cyc, out_vec);
        end else begin
          ev = exp_q.pop_front(); es = exp_s.pop_front();
          if (out_vec !== ev || out_sat !== es) begin
            errors++; $display("FAIL stream_%0d got=%h/%b want=%h/%b", got, out_vec, out_sat, ev, es);
          end
          if (es) nsat++;
        end
        checks++;
        got++;
      end
      held = out_valid && !out_ready;
      pv = out_vec; ps = out_sat;
    end
    gate_valid = 0; up_valid = 0; out_ready = 1;
    @(negedge clk);
    if (got !== NVEC || exp_q.size() != 0) begin
      errors++; $display("FAIL stream_count got=%0d left=%0d want=%0d/0", got, exp_q.size(), NVEC);
    end
    checks++;
    if (sat_count !== CW'(nsat)) begin
      errors++; $display("FAIL stream_sat_count got=%0d want=%0d", sat_count, nsat);
    end
    checks++;
  endtask

  task automatic test_reset_inflight();
    int nout;
    @(negedge clk);
    out_ready = 0;
    gate_vec = {DIM{16'h7FFF}}; up_vec = {DIM{16'h7FFF}};
    gate_valid = 1; up_valid = 1;
    @(negedge clk);
    gate_vec = {DIM{16'h0100}}; up_vec = {DIM{16'h0100}};
    @(negedge clk);
    #1;
    if (gate_ready !== 1'b0 || up_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL full_backpressure ready=%b/%b out_valid=%b want=0/0/1", gate_ready, up_ready, out_valid);
    end
    checks++;
    #2 rst_n = 0;
    #1;
    if (out_valid !== 1'b0 || out_vec !== '0 || out_sat !== 1'b0 || sat_count !== '0) begin
      errors++; $display("FAIL async_reset got=%b/%h/%b/%0d want=0/0/0/0", out_valid, out_vec, out_sat, sat_count);
    end
    checks++;
    gate_valid = 0; up_valid = 0;
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    nout = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) nout++;
    end
    if (nout !== 0) begin errors++; $display("FAIL stale_after_reset got=%0d want=0", nout); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_sat();
    test_join_skew();
    test_back_to_back();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
